// File: rtl/cla_seq_addsub.sv
// Multi-cycle add/subtract unit that reuses a single 4-bit carry-lookahead
// adder one nibble per clock, least significant nibble first.

module cla_nibble (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [4:0] c_s;

  assign g_s = a_i & b_i;
  assign p_s = a_i ^ b_i;

  // Carries computed in parallel from generate/propagate terms.
  always_comb begin
    c_s[0] = c_i;
    c_s[1] = g_s[0] | (p_s[0] & c_i);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_i);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & c_i);
    c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
           | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_i);
  end

  assign s_o = p_s ^ c_s[3:0];
  assign c_o = c_s[4];
endmodule

module cla_seq_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [IDXW+1:0]   bitpos_s;
  logic [3:0]        cla_s_s;
  logic              cla_c_s;

  assign bitpos_s = {idx_q, 2'b00};

  cla_nibble u_cla (
    .a_i (a_q[bitpos_s +: 4]),
    .b_i (b_q[bitpos_s +: 4]),
    .c_i (carry_q),
    .s_o (cla_s_s),
    .c_o (cla_c_s)
  );

  // Next-state and datapath update; result/flags only move on the last nibble.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Subtract is a + ~b + 1: invert B and seed the carry with 1.
          a_d     = a;
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub;
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d[bitpos_s +: 4] = cla_s_s;
        carry_d = cla_c_s;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == IDXW'(NIB - 1)) begin
          state_d  = S_DONE;
          result_d = sum_d;
          cout_d   = cla_c_s;
          ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d   = (sum_d == '0);
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      sum_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
endmodule
